// File: rtl/uart_tx_fifo.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_fifo
// Brief    : Byte FIFO feeding the uart tx_latch/tx_data/tx_empty handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  uart_tx_empty,
  output logic                  uart_tx_latch,
  output logic [7:0]            uart_tx_data
);

  localparam int                c_DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = (DEPTH_LOG2 + 1)'(c_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_LATCH = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [7:0]            r_tx_data;
  logic                  w_push_ok;
  logic                  w_pop;

  assign full          = (r_count == c_FULL_COUNT);
  assign empty         = (r_count == '0);
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign uart_tx_latch = (r_state == S_LATCH);
  assign uart_tx_data  = r_tx_data;

  // No bypass: a push while full is dropped even if a pop happens this cycle.
  assign w_push_ok = push && !full && !flush;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush && !empty && uart_tx_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_LATCH;
        end
      end
      S_LATCH: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
      end
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (push && full) begin
          r_overflow <= 1'b1;
        end
        if (w_push_ok) begin
          r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
        end
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
          2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_fifo
// Brief    : Directed scoreboard bench for uart_tx_fifo.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       flush = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       uart_tx_empty;
  logic       uart_tx_latch;
  logic [7:0] uart_tx_data;

  logic       tx_manual = 1'b1;
  logic       model_en = 1'b0;
  logic       model_ready = 1'b1;
  int         busy = 0;

  int         tests = 0;
  int         fails = 0;
  int         strobes = 0;
  int         base;
  logic       prev_latch = 1'b0;
  logic [7:0] sb[$];

  assign uart_tx_empty = model_en ? model_ready : tx_manual;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_data     (push_data),
    .flush         (flush),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .uart_tx_empty (uart_tx_empty),
    .uart_tx_latch (uart_tx_latch),
    .uart_tx_data  (uart_tx_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Uart model: busy for 20 cycles after each strobe it registers.
  always @(negedge clk) begin
    if (uart_tx_latch) begin
      model_ready = 1'b0;
      busy        = 20;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) model_ready = 1'b1;
    end
  end

  // Strobe monitor: every strobe is one cycle wide and carries the queue head.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (uart_tx_latch) begin
      strobes++;
      chk("latch_width", {31'b0, prev_latch}, 32'd0);
      chk("strobe_expected", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        chk("tx_data", {24'b0, uart_tx_data}, {24'b0, exp_b});
      end
    end
    prev_latch = uart_tx_latch;
  end

  task automatic push_byte(input logic [7:0] d, input bit accept);
    push      = 1'b1;
    push_data = d;
    if (accept) sb.push_back(d);
    tick();
    push = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_count", {27'b0, count}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_latch", {31'b0, uart_tx_latch}, 32'd0);
    chk("rst_data", {24'b0, uart_tx_data}, 32'd0);

    // 1: single byte latency
    tx_manual = 1'b1;
    push_byte(8'h55, 1'b1);
    chk("t1_empty_fall", {31'b0, empty}, 32'd0);
    chk("t1_latch_k", {31'b0, uart_tx_latch}, 32'd0);
    tick();
    chk("t1_latch_k1", {31'b0, uart_tx_latch}, 32'd1);
    chk("t1_data", {24'b0, uart_tx_data}, 32'h55);
    chk("t1_count", {27'b0, count}, 32'd0);
    tick();
    chk("t1_latch_k2", {31'b0, uart_tx_latch}, 32'd0);
    chk("t1_empty_end", {31'b0, empty}, 32'd1);
    chk("t1_strobes", strobes, 32'd1);

    // 2: fill while uart busy, overflow on 17th push
    do_reset();
    tx_manual = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    chk("t2_full", {31'b0, full}, 32'd1);
    chk("t2_ovf_before", {31'b0, overflow}, 32'd0);
    push_byte(8'hAA, 1'b0);
    chk("t2_count", {27'b0, count}, 32'd16);
    chk("t2_overflow", {31'b0, overflow}, 32'd1);

    // 3: drain through the busy uart model
    base     = strobes;
    model_en = 1'b1;
    for (int i = 0; i < 600 && strobes < base + 16; i++) tick();
    tick();
    chk("t3_strobes", strobes - base, 32'd16);
    chk("t3_empty", {31'b0, empty}, 32'd1);
    chk("t3_sb_drained", sb.size(), 32'd0);
    for (int i = 0; i < 25; i++) tick();
    model_en  = 1'b0;
    tx_manual = 1'b0;

    // 4: push while full in the same cycle as a pop
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 1'b1);
    chk("t4_full", {31'b0, full}, 32'd1);
    tx_manual = 1'b1;
    push_byte(8'h77, 1'b0);
    tx_manual = 1'b0;
    chk("t4_latch", {31'b0, uart_tx_latch}, 32'd1);
    chk("t4_count", {27'b0, count}, 32'd15);
    chk("t4_overflow", {31'b0, overflow}, 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    chk("t4_flush_ovf", {31'b0, overflow}, 32'd0);
    chk("t4_flush_count", {27'b0, count}, 32'd0);

    // 5: flush during LATCH
    push_byte(8'hA1, 1'b1);
    push_byte(8'hA2, 1'b1);
    push_byte(8'hA3, 1'b1);
    chk("t5_count3", {27'b0, count}, 32'd3);
    base      = strobes;
    tx_manual = 1'b1;
    tick();
    chk("t5_in_latch", {31'b0, uart_tx_latch}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    chk("t5_count", {27'b0, count}, 32'd0);
    chk("t5_empty", {31'b0, empty}, 32'd1);
    chk("t5_overflow", {31'b0, overflow}, 32'd0);
    chk("t5_data_hold", {24'b0, uart_tx_data}, 32'hA1);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_strobes", strobes - base, 32'd1);

    // 6: reset while in LATCH with 5 bytes queued
    tx_manual = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'hC0 + 8'(i), 1'b1);
    tx_manual = 1'b1;
    tick();
    chk("t6_in_latch", {31'b0, uart_tx_latch}, 32'd1);
    chk("t6_count5", {27'b0, count}, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    base = strobes;
    chk("t6_latch", {31'b0, uart_tx_latch}, 32'd0);
    chk("t6_data", {24'b0, uart_tx_data}, 32'd0);
    chk("t6_count", {27'b0, count}, 32'd0);
    chk("t6_empty", {31'b0, empty}, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_strobe", strobes - base, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
